// File: rtl/counter_sched_if.sv
// Handshake bundle between counter_sched and its requesters / shared counter.
interface counter_sched_if #(
  parameter int unsigned W = 4
);
  logic [1:0]   req;
  logic [W-1:0] len0;
  logic [W-1:0] len1;
  logic [W-1:0] cnt_val;
  logic         cnt_rst;
  logic         cnt_en;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic         busy;

  modport master (
    output req, len0, len1, cnt_val,
    input  cnt_rst, cnt_en, gnt, done, busy
  );

  modport slave (
    input  req, len0, len1, cnt_val,
    output cnt_rst, cnt_en, gnt, done, busy
  );
endinterface

// File: rtl/counter_sched.sv
// Two-requester scheduler time-sharing one external counter (IDLE/CLR/RUN/DONE).
// Define CNT_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module counter_sched #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  counter_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] len_q, len_d;
  logic         g_q, g_d;
  logic         last_q, last_d;
  logic         win;
  logic [1:0]   g_onehot;

`ifdef CNT_SCHED_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last_q;

  always_comb begin
    win = ~bus.req[0];
  end
`else
  // Only a tie consults the pointer; a lone request always wins.
  always_comb begin
    if (bus.req == 2'b11) win = ~last_q;
    else                  win = bus.req[1];
  end
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    g_d     = g_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          g_d     = win;
          len_d   = win ? bus.len1 : bus.len0;
          state_d = CLR;
        end
      end
      CLR: begin
        if (!bus.req[g_q]) begin
          state_d = IDLE;
          last_d  = g_q;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort takes precedence over completion: no done pulse once req drops.
        if (!bus.req[g_q]) begin
          state_d = IDLE;
          last_d  = g_q;
        end else if (bus.cnt_val == len_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = g_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      g_q     <= g_d;
      last_q  <= last_d;
    end
  end

  // Counter is held cleared in IDLE as well, which covers the reset case.
  assign g_onehot    = g_q ? 2'b10 : 2'b01;
  assign bus.busy    = (state_q != IDLE);
  assign bus.gnt     = (state_q != IDLE) ? g_onehot : 2'b00;
  assign bus.done    = (state_q == DONE) ? g_onehot : 2'b00;
  assign bus.cnt_rst = (state_q == IDLE) || (state_q == CLR);
  assign bus.cnt_en  = (state_q == RUN) && (bus.cnt_val != len_q);

endmodule
